// File: rtl/aes_pkg.sv
// AES shared types, S-box table and GF(2^8) helpers.
// Key-length-dependent sizes are derived through the *_of functions.
package aes_pkg;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      KE_IDLE,
      KE_EXPAND,
      KE_DONE
   } ke_state_e;

   function automatic int nk_of(int keylen);
      return keylen / 32;
   endfunction

   function automatic int nr_of(int keylen);
      return nk_of(keylen) + 6;
   endfunction

   function automatic int nw_of(int keylen);
      return 4 * (nr_of(keylen) + 1);
   endfunction

   localparam int NK128 = nk_of(128);
   localparam int NR128 = nr_of(128);
   localparam int NW128 = nw_of(128);

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load handshake and round-key output bundle for aes_key_expand.
// master = key source / cipher pipe, slave = key schedule.
interface aes_key_expand_if #(parameter int KEYLEN = 128) ();
   import aes_pkg::*;

   localparam int NR = nr_of(KEYLEN);

   logic                   key_valid;
   logic                   key_ready;
   logic [KEYLEN-1:0]      key_in;
   logic                   pipe_idle;
   logic                   keys_valid;
   aes_block_t [NR:0]      expanded_key;

   modport master (
      output key_valid, key_in, pipe_idle,
      input  key_ready, keys_valid, expanded_key
   );

   modport slave (
      input  key_valid, key_in, pipe_idle,
      output key_ready, keys_valid, expanded_key
   );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
   import aes_pkg::*;
(
   input  aes_word_t in_word,
   output aes_word_t out_word
);

   assign out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                      sbox(in_word[15:8]),  sbox(in_word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one schedule word per cycle, result
// held stable until the cipher pipe drains and a new key is taken.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int KEYLEN = 128
) (
   input logic          clk,
   input logic          rst,
   aes_key_expand_if.slave bus
);

   localparam int NK = nk_of(KEYLEN);
   localparam int NR = nr_of(KEYLEN);
   localparam int NW = nw_of(KEYLEN);
   localparam int IW = $clog2(NW);

   ke_state_e        state_q, state_d;
   logic [IW-1:0]    i_q, i_d;
   logic [2:0]       j_q, j_d;
   logic [7:0]       rcon_q, rcon_d;
   aes_word_t        w_q [NW];
   aes_word_t        w_d [NW];

   aes_word_t        w_prev, w_back, sub_in, sub_out, t;
   logic             key_ready;

   assign w_prev = w_q[i_q - 1'b1];
   assign w_back = w_q[i_q - IW'(NK)];
   assign sub_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]}
                                 : w_prev;

   aes_sub_word u_sub_word (
      .in_word  (sub_in),
      .out_word (sub_out)
   );

   always_comb begin
      t = w_prev;
      if (j_q == 3'd0)
         t = sub_out ^ {rcon_q, 24'h0};
      else if (NK == 8 && j_q == 3'd4)
         t = sub_out;
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      rcon_d    = rcon_q;
      w_d       = w_q;
      key_ready = 1'b0;
      unique case (state_q)
         KE_IDLE: key_ready = 1'b1;
         KE_DONE: key_ready = bus.pipe_idle;
         KE_EXPAND: begin
            w_d[i_q] = w_back ^ t;
            i_d      = i_q + 1'b1;
            j_d      = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0)
               rcon_d = xtime(rcon_q);
            if (i_q == IW'(NW - 1))
               state_d = KE_DONE;
         end
         default: state_d = KE_IDLE;
      endcase
      if (bus.key_valid && key_ready) begin
         for (int k = 0; k < NK; k++)
            w_d[k] = bus.key_in[KEYLEN-1-32*k -: 32];
         i_d     = IW'(NK);
         j_d     = 3'd0;
         rcon_d  = 8'h01;
         state_d = KE_EXPAND;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= KE_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         rcon_q  <= '0;
         for (int k = 0; k < NW; k++)
            w_q[k] <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         w_q     <= w_d;
      end
   end

   assign bus.key_ready  = key_ready;
   assign bus.keys_valid = (state_q == KE_DONE);

   // Word store maps straight onto the round-key packing.
   for (genvar r = 0; r <= NR; r++) begin : g_rk
      assign bus.expanded_key[r] = {w_q[4*r], w_q[4*r+1],
                                    w_q[4*r+2], w_q[4*r+3]};
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand at all three key lengths against an
// independent key-schedule model (S-box derived from GF(2^8) math).
module tb_aes_key_expand;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_key_expand_if #(.KEYLEN(128)) i128 ();
   aes_key_expand_if #(.KEYLEN(192)) i192 ();
   aes_key_expand_if #(.KEYLEN(256)) i256 ();

   aes_key_expand #(.KEYLEN(128)) u128 (.clk(clk), .rst(rst), .bus(i128));
   aes_key_expand #(.KEYLEN(192)) u192 (.clk(clk), .rst(rst), .bus(i192));
   aes_key_expand #(.KEYLEN(256)) u256 (.clk(clk), .rst(rst), .bus(i256));

   int tests = 0;
   int fails = 0;

   logic [7:0]  ref_sbox [256];
   logic [31:0] ref_w [60];

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int n = 0; n < 8; n++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(logic [7:0] x, int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
         ref_sbox[a] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^
                       rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(logic [31:0] x);
      return {ref_sbox[x[31:24]], ref_sbox[x[23:16]],
              ref_sbox[x[15:8]], ref_sbox[x[7:0]]};
   endfunction

   // Key is left-aligned in 256 bits; fills ref_w[0..NW-1].
   function automatic void build_ref(logic [255:0] key, int nk);
      logic [31:0] t;
      logic [7:0]  rc;
      int nw = 4 * (nk + 7);
      for (int k = 0; k < nk; k++)
         ref_w[k] = key[255-32*k -: 32];
      for (int i = nk; i < nw; i++) begin
         t = ref_w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int p = 1; p < i / nk; p++) rc = gmul(rc, 8'h02);
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         ref_w[i] = ref_w[i-nk] ^ t;
      end
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] r = '0;
      for (int n = 0; n < 8; n++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   function automatic int nk_sel(int sel);
      return (sel == 0) ? 4 : (sel == 1) ? 6 : 8;
   endfunction

   task automatic set_in(int sel, logic v, logic [255:0] key);
      case (sel)
         0: begin i128.key_valid = v; i128.key_in = key[255 -: 128]; end
         1: begin i192.key_valid = v; i192.key_in = key[255 -: 192]; end
         default: begin i256.key_valid = v; i256.key_in = key; end
      endcase
   endtask

   task automatic set_idle(int sel, logic v);
      case (sel)
         0: i128.pipe_idle = v;
         1: i192.pipe_idle = v;
         default: i256.pipe_idle = v;
      endcase
   endtask

   function automatic logic kv(int sel);
      case (sel)
         0: return i128.keys_valid;
         1: return i192.keys_valid;
         default: return i256.keys_valid;
      endcase
   endfunction

   function automatic logic kr(int sel);
      case (sel)
         0: return i128.key_ready;
         1: return i192.key_ready;
         default: return i256.key_ready;
      endcase
   endfunction

   function automatic logic [31:0] dut_word(int sel, int idx);
      logic [127:0] blk;
      int r = idx / 4;
      int k = idx % 4;
      case (sel)
         0: blk = i128.expanded_key[r];
         1: blk = i192.expanded_key[r];
         default: blk = i256.expanded_key[r];
      endcase
      return blk[127-32*k -: 32];
   endfunction

   // Accept a key, time keys_valid, then compare the whole schedule.
   task automatic expand_and_check(int sel, logic [255:0] key,
                                   bit toggle, string name);
      int nk = nk_sel(sel);
      int nw = 4 * (nk + 7);
      int n, bad, first;
      build_ref(key, nk);
      @(negedge clk);
      set_idle(sel, 1'b1);
      set_in(sel, 1'b1, key);
      @(posedge clk);
      @(negedge clk);
      set_in(sel, 1'b0, key);
      n = 0;
      tests++;
      if (kv(sel) !== 1'b0) begin
         fails++;
         $display("FAIL %s kv_after_accept: got %b want 0", name, kv(sel));
      end
      while (n < 200 && kv(sel) !== 1'b1) begin
         if (toggle) begin
            tests++;
            if (kr(sel) !== 1'b0) begin
               fails++;
               $display("FAIL %s ready_in_expand: got %b want 0", name, kr(sel));
            end
            set_in(sel, 1'($urandom_range(0, 1)), rand_key());
         end
         @(negedge clk);
         n++;
      end
      set_in(sel, 1'b0, key);
      tests++;
      if (n != nw - nk) begin
         fails++;
         $display("FAIL %s latency: got %0d want %0d", name, n, nw - nk);
      end
      bad = 0;
      first = -1;
      for (int k = 0; k < nw; k++)
         if (dut_word(sel, k) !== ref_w[k]) begin
            bad++;
            if (first < 0) first = k;
         end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s schedule: %0d bad words, w[%0d] got %h want %h",
                  name, bad, first, dut_word(sel, first), ref_w[first]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         tests++;
         if (kr(s) !== 1'b1 || kv(s) !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags[%0d]: ready=%b valid=%b want 1/0",
                     s, kr(s), kv(s));
         end
      end
      tests++;
      if (i128.expanded_key !== '0 || i192.expanded_key !== '0 ||
          i256.expanded_key !== '0) begin
         fails++;
         $display("FAIL reset_keys: expanded_key not all zero, e0=%h",
                  i128.expanded_key[0]);
      end
   endtask

   task automatic test_vectors();
      expand_and_check(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                       1'b0, "fips128");
      tests++;
      if (i128.expanded_key[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
         fails++;
         $display("FAIL fips128_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6",
                  i128.expanded_key[10]);
      end
      tests++;
      if (i128.expanded_key[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
         fails++;
         $display("FAIL fips128_rk0: got %h want key", i128.expanded_key[0]);
      end
      expand_and_check(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                           64'h0}, 1'b0, "fips192");
      tests++;
      if (dut_word(1, 51) !== 32'h01002202) begin
         fails++;
         $display("FAIL fips192_w51: got %h want 01002202", dut_word(1, 51));
      end
      expand_and_check(2,
         256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
         1'b0, "fips256");
      tests++;
      if (dut_word(2, 59) !== 32'h706c631e) begin
         fails++;
         $display("FAIL fips256_w59: got %h want 706c631e", dut_word(2, 59));
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 3; s++)
         for (int r = 0; r < 3; r++)
            expand_and_check(s, rand_key(), 1'b0, "random");
   endtask

   task automatic test_key_toggle();
      expand_and_check(0, rand_key(), 1'b1, "toggle128");
      expand_and_check(2, rand_key(), 1'b1, "toggle256");
   endtask

   task automatic test_pipe_hold();
      logic [255:0] nkey = rand_key();
      logic [10:0][127:0] snap = i128.expanded_key;
      @(negedge clk);
      set_idle(0, 1'b0);
      set_in(0, 1'b1, nkey);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         tests++;
         if (kr(0) !== 1'b0 || kv(0) !== 1'b1) begin
            fails++;
            $display("FAIL hold_flags[%0d]: ready=%b valid=%b want 0/1",
                     c, kr(0), kv(0));
         end
         tests++;
         if (i128.expanded_key !== snap) begin
            fails++;
            $display("FAIL hold_keys[%0d]: rk0 got %h want %h",
                     c, i128.expanded_key[0], snap[0]);
         end
      end
      expand_and_check(0, nkey, 1'b0, "after_drain");
   endtask

   task automatic test_mid_reset();
      logic [255:0] key = rand_key();
      @(negedge clk);
      set_in(0, 1'b1, key);
      @(posedge clk);
      @(negedge clk);
      set_in(0, 1'b0, key);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      set_in(0, 1'b1, rand_key());
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 1'b0, key);
      tests++;
      if (kr(0) !== 1'b1 || kv(0) !== 1'b0) begin
         fails++;
         $display("FAIL midrst_flags: ready=%b valid=%b want 1/0", kr(0), kv(0));
      end
      tests++;
      if (i128.expanded_key !== '0) begin
         fails++;
         $display("FAIL midrst_keys: rk0 got %h want 0", i128.expanded_key[0]);
      end
      expand_and_check(0, rand_key(), 1'b0, "after_rst");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 3; s++) begin
         set_in(s, 1'b0, '0);
         set_idle(s, 1'b1);
      end
      init_sbox();
      test_reset();
      test_vectors();
      test_random();
      test_key_toggle();
      test_pipe_hold();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES key schedule (FIPS-197) that sits directly upstream of the encrypt pipeline's `expanded_key` input. It accepts a cipher key over a valid/ready handshake and computes one 32-bit schedule word per cycle. It then holds the full round-key set stable until the pipeline has drained and a new key is accepted. This trades about 40–52 cycles of rekey latency for a single S-box word path instead of ten or more unrolled key rounds.

## Interface
- `KEYLEN`, default 128: cipher key length; legal values 128, 192, 256. Derived: Nk = KEYLEN/32, Nr = Nk+6, NW = 4(Nr+1) (44/52/60).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `key_valid`  in  1  `key_in` is offered.
- `key_ready`  out  1  block can accept a key this cycle.
- `key_in`  in  KEYLEN  cipher key; byte 0 (first FIPS byte) in bits [KEYLEN-1:KEYLEN-8].
- `pipe_idle`  in  1  downstream encrypt pipe holds no in-flight blocks.
- `keys_valid`  out  1  `expanded_key` is complete and stable.
- `expanded_key`  out  (Nr+1)×128, packed [Nr:0][127:0]  round keys.
  - Entry r holds word w[4r] in [127:96], w[4r+1] in [95:64], w[4r+2] in [63:32] and w[4r+3] in [31:0].
  - Within each word, the first byte is in the MSB.

## Operation
- FSM states are IDLE, EXPAND and DONE. Reset enters IDLE.
- `key_ready` is combinational:
  - 1 in IDLE;
  - `pipe_idle` in DONE;
  - 0 in EXPAND.
- Acceptance occurs when `key_valid && key_ready` at a clock edge. On that edge:
  - w[0..Nk-1] ← `key_in`;
  - word index i ← Nk;
  - phase counter j ← 0 (j = i mod Nk);
  - rcon ← 0x01;
  - state → EXPAND.
- In EXPAND, each edge writes w[i] = w[i-Nk] ^ t, where the temporary t is derived from w[i-1]:
  - if j == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, and rcon ← xtime(rcon);
  - else if Nk == 8 and j == 4: t = SubWord(w[i-1]);
  - otherwise: t = w[i-1].
- After each write, i increments by 1 and j wraps from Nk-1 to 0.
- The edge that writes w[NW-1] also moves the state to DONE.
- DONE:
  - `keys_valid` = 1;
  - `expanded_key` is held constant;
  - a new acceptance returns the FSM to EXPAND.
- `key_in` is sampled only at acceptance. Later changes to `key_in` are ignored.
- `key_valid` during EXPAND, or during DONE with `pipe_idle` = 0, is ignored, with no side effects.
- Consumers must not issue blocks while `keys_valid` = 0. `expanded_key` contents are not meaningful then.

## Timing
- Reset values:
  - state IDLE;
  - `keys_valid` 0;
  - `key_ready` 1;
  - all `expanded_key` bits 0;
  - i, j and rcon are don't-care until loaded at acceptance.
- Latency: with acceptance on edge E0, `keys_valid` goes high after edge E0+L, where L = NW−Nk (40/46/52 for 128/192/256).
- Throughput: one word per cycle. A back-to-back rekey costs L cycles plus the wait for `pipe_idle`.
- `keys_valid` falls in the cycle after a DONE-state acceptance. Schedule words are overwritten progressively from that edge on.
- `rst` asserted in any state, including mid-EXPAND, returns all outputs to their reset values on the next edge. Reset has priority over acceptance in the same cycle.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. It is consumed only on j == 0 edges.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box constant table and `sbox(byte)` function;
  - `xtime`;
  - word and round-key typedefs (`aes_word_t`, `aes_block_t`);
  - localparams for Nk/Nr/NW as functions of KEYLEN.
- One sub-module, `aes_sub_word`: four combinational S-box lookups, 32-bit in to 32-bit out. It is reusable by the round logic.
- The word store is NW×32 flops. It maps directly onto the `expanded_key` packing, with no reordering logic.

## Test plan
- KEYLEN=128, key 2b7e151628aed2a6abf7158809cf4f3c → `keys_valid` 40 cycles after acceptance; entry 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; entry 0 equals the key.
- KEYLEN=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → `keys_valid` after 46 cycles; w[51] = 01002202.
- KEYLEN=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → `keys_valid` after 52 cycles; w[59] = 706c631e. This exercises the j==4 SubWord path.
- In DONE with `pipe_idle`=0, hold `key_valid`=1 with a new key for 20 cycles → `key_ready`=0 and `expanded_key` unchanged. Raise `pipe_idle` → acceptance on that edge, `keys_valid` drops next cycle, and the new schedule is valid 40 cycles later.
- Assert `rst` at cycle 20 of an expansion → next cycle shows IDLE, `key_ready`=1, `keys_valid`=0 and `expanded_key`=0. A fresh key then expands correctly.
- Toggle `key_in` every cycle during EXPAND → result matches the key sampled at acceptance.
